pwd_auth_ctrl_p: RTL and testbench

//   Parametrised password authentication controller; sits after user-ID check, before game unlock.

---
 rtl/pwd_pkg.sv | 40 ++++
 rtl/pwd_auth_ctrl_p_timer.sv | 33 +++
 rtl/pwd_auth_ctrl_p.sv | 218 +++++++++++++++++++++
 tb/tb_pwd_auth_ctrl_p.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwd_pkg.sv
// Shared definitions for the password authentication controller:
// state encoding, derived-width helpers and the controller state type.
package pwd_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENTER   = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_CATCH   = 3'd4;
  localparam logic [2:0] S_COMPARE = 3'd5;
  localparam logic [2:0] S_GRANTED = 3'd6;
  localparam logic [2:0] S_LOCKED  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_ENTER   = S_ENTER,
    ST_FETCH   = S_FETCH,
    ST_WAIT    = S_WAIT,
    ST_CATCH   = S_CATCH,
    ST_COMPARE = S_COMPARE,
    ST_GRANTED = S_GRANTED,
    ST_LOCKED  = S_LOCKED
  } state_t;

  // Total bits of a whole password (digit 0 lives in the MSBs).
  function automatic int pwd_width(input int num_digits, input int digit_w);
    return num_digits * digit_w;
  endfunction

  // Bits needed to index 0..num_digits-1 (never narrower than 1).
  function automatic int idx_width(input int num_digits);
    return (num_digits <= 1) ? 1 : $clog2(num_digits);
  endfunction

  // Bits needed to hold the value n itself (never narrower than 1).
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pwd_auth_ctrl_p_timer.sv
// Lockout countdown: loaded with LOCK_CYC, decrements while enabled,
// and flags the final cycle of the lockout so the FSM leaves on time.
module pwd_lockout_timer
  import pwd_pkg::*;
#(
  parameter int LOCK_CYC = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int CNT_W = count_width(LOCK_CYC);

  logic [CNT_W-1:0] cnt_reg;

  // Reload on request, otherwise count down towards zero while enabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= CNT_W'(LOCK_CYC);
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  // Last lockout cycle: the FSM exits on this edge so lock lasts LOCK_CYC cycles.
  assign done = en && (cnt_reg <= CNT_W'(1));

endmodule

// File: rtl/pwd_auth_ctrl_p.sv
// Password authentication controller: captures an entered password, reads the
// stored one from an external synchronous ROM digit by digit, compares them,
// and manages retries with a timed lockout after too many failures.
module pwd_auth_ctrl_p
  import pwd_pkg::*;
#(
  parameter int DIGIT_W    = 4,
  parameter int NUM_DIGITS = 4,
  parameter int ADDR_W     = 5,
  parameter int ROM_LAT    = 2,
  parameter int MAX_TRIES  = 3,
  parameter int LOCK_CYC   = 1000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             user_id_ok,
  input  logic                             load_digit,
  input  logic [DIGIT_W-1:0]               digit_in,
  input  logic [ADDR_W-1:0]                base_addr,
  input  logic                             logout,
  output logic [ADDR_W-1:0]                rom_addr,
  input  logic [DIGIT_W-1:0]               rom_data,
  output logic                             green_led,
  output logic                             red_led,
  output logic                             lock_led,
  output logic [DIGIT_W-1:0]               digit_display,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left
);

  localparam int PWD_W  = pwd_width(NUM_DIGITS, DIGIT_W);
  localparam int IDX_W  = idx_width(NUM_DIGITS);
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int WAIT_W = count_width(ROM_LAT);

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [TRY_W-1:0]  TRIES_INIT = TRY_W'(MAX_TRIES);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(ROM_LAT - 1);

  state_t              state_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [WAIT_W-1:0]   wait_cnt_reg;
  logic [ADDR_W-1:0]   base_reg;
  logic [ADDR_W-1:0]   rom_addr_reg;
  logic [DIGIT_W-1:0]  entered_reg [NUM_DIGITS];
  logic [DIGIT_W-1:0]  stored_reg  [NUM_DIGITS];
  logic [DIGIT_W-1:0]  display_reg;
  logic [TRY_W-1:0]    tries_reg;
  logic                green_reg;
  logic                red_reg;
  logic                lock_reg;

  logic [PWD_W-1:0]    entered_flat;
  logic [PWD_W-1:0]    stored_flat;
  logic                pwd_match;
  logic                timer_load;
  logic                timer_en;
  logic                timer_done;

  // Digit 0 occupies the MSBs of the flattened password vectors.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_flat
    assign entered_flat[PWD_W-1-gi*DIGIT_W -: DIGIT_W] = entered_reg[gi];
    assign stored_flat[PWD_W-1-gi*DIGIT_W -: DIGIT_W]  = stored_reg[gi];
  end

  assign pwd_match = (entered_flat == stored_flat);

  // Preloading in COMPARE is harmless: the count only matters once LOCKED.
  assign timer_load = (state_reg == ST_COMPARE);
  assign timer_en   = (state_reg == ST_LOCKED);

  pwd_lockout_timer #(
    .LOCK_CYC (LOCK_CYC)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .en    (timer_en),
    .done  (timer_done)
  );

  // Main controller: entry capture, ROM fetch sequencing, compare, retry and lockout.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      wait_cnt_reg <= '0;
      base_reg     <= '0;
      rom_addr_reg <= '0;
      display_reg  <= '0;
      tries_reg    <= TRIES_INIT;
      green_reg    <= 1'b0;
      red_reg      <= 1'b1;
      lock_reg     <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        entered_reg[i] <= '0;
        stored_reg[i]  <= '0;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (user_id_ok) state_reg <= ST_ENTER;
        end

        ST_ENTER, ST_FETCH, ST_WAIT, ST_CATCH, ST_COMPARE: begin
          if (!user_id_ok) begin
            // Losing the user ID throws away any partial entry but keeps the retry count.
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
              entered_reg[i] <= '0;
              stored_reg[i]  <= '0;
            end
          end else begin
            case (state_reg)
              ST_ENTER: begin
                if (load_digit) begin
                  entered_reg[idx_reg] <= digit_in;
                  display_reg          <= digit_in;
                  if (idx_reg == LAST_IDX) begin
                    idx_reg   <= '0;
                    base_reg  <= base_addr;
                    state_reg <= ST_FETCH;
                  end else begin
                    idx_reg <= idx_reg + IDX_W'(1);
                  end
                end
              end
              ST_FETCH: begin
                rom_addr_reg <= base_reg + ADDR_W'(idx_reg);
                wait_cnt_reg <= '0;
                state_reg    <= ST_WAIT;
              end
              ST_WAIT: begin
                if (wait_cnt_reg == WAIT_LAST) state_reg <= ST_CATCH;
                else wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
              end
              ST_CATCH: begin
                stored_reg[idx_reg] <= rom_data;
                if (idx_reg == LAST_IDX) begin
                  idx_reg   <= '0;
                  state_reg <= ST_COMPARE;
                end else begin
                  idx_reg   <= idx_reg + IDX_W'(1);
                  state_reg <= ST_FETCH;
                end
              end
              default: begin  // ST_COMPARE
                if (pwd_match) begin
                  green_reg <= 1'b1;
                  red_reg   <= 1'b0;
                  tries_reg <= TRIES_INIT;
                  state_reg <= ST_GRANTED;
                end else begin
                  tries_reg <= tries_reg - TRY_W'(1);
                  idx_reg   <= '0;
                  for (int i = 0; i < NUM_DIGITS; i++) entered_reg[i] <= '0;
                  if (tries_reg == TRY_W'(1)) begin
                    lock_reg  <= 1'b1;
                    state_reg <= ST_LOCKED;
                  end else begin
                    state_reg <= ST_ENTER;
                  end
                end
              end
            endcase
          end
        end

        ST_GRANTED: begin
          if (logout) begin
            state_reg   <= ST_IDLE;
            green_reg   <= 1'b0;
            red_reg     <= 1'b1;
            display_reg <= '0;
            idx_reg     <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
              entered_reg[i] <= '0;
              stored_reg[i]  <= '0;
            end
          end
        end

        ST_LOCKED: begin
          if (timer_done) begin
            lock_reg  <= 1'b0;
            tries_reg <= TRIES_INIT;
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          state_reg    <= ST_IDLE;
          idx_reg      <= '0;
          wait_cnt_reg <= '0;
          base_reg     <= '0;
          rom_addr_reg <= '0;
          display_reg  <= '0;
          tries_reg    <= TRIES_INIT;
          green_reg    <= 1'b0;
          red_reg      <= 1'b1;
          lock_reg     <= 1'b0;
          for (int i = 0; i < NUM_DIGITS; i++) begin
            entered_reg[i] <= '0;
            stored_reg[i]  <= '0;
          end
        end
      endcase
    end
  end

  assign rom_addr      = rom_addr_reg;
  assign green_led     = green_reg;
  assign red_led       = red_reg;
  assign lock_led      = lock_reg;
  assign digit_display = display_reg;
  assign tries_left    = tries_reg;

endmodule

// File: tb/tb_pwd_auth_ctrl_p.sv
// Self-checking bench for pwd_auth_ctrl_p: a default instance (A) and a wide,
// short-latency instance (B), each fed by a behavioural synchronous ROM.
module tb_pwd_auth_ctrl_p;

  localparam int DW = 4, ND = 4, AW = 5, RL = 2, MT = 3, LC = 1000;
  localparam int B_DW = 8, B_ND = 6, B_RL = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, user_id_ok, load_digit, logout;
  logic [DW-1:0] digit_in, rom_data, digit_display;
  logic [AW-1:0] base_addr, rom_addr;
  logic          green_led, red_led, lock_led;
  logic [1:0]    tries_left;

  logic            b_user_id_ok, b_load_digit, b_logout;
  logic [B_DW-1:0] b_digit_in, b_rom_data, b_digit_display;
  logic [AW-1:0]   b_base_addr, b_rom_addr;
  logic            b_green_led, b_red_led, b_lock_led;
  logic [1:0]      b_tries_left;

  pwd_auth_ctrl_p dut_a (
    .clk(clk), .reset(reset), .user_id_ok(user_id_ok), .load_digit(load_digit),
    .digit_in(digit_in), .base_addr(base_addr), .logout(logout), .rom_addr(rom_addr),
    .rom_data(rom_data), .green_led(green_led), .red_led(red_led), .lock_led(lock_led),
    .digit_display(digit_display), .tries_left(tries_left)
  );

  pwd_auth_ctrl_p #(.DIGIT_W(B_DW), .NUM_DIGITS(B_ND), .ROM_LAT(B_RL)) dut_b (
    .clk(clk), .reset(reset), .user_id_ok(b_user_id_ok), .load_digit(b_load_digit),
    .digit_in(b_digit_in), .base_addr(b_base_addr), .logout(b_logout), .rom_addr(b_rom_addr),
    .rom_data(b_rom_data), .green_led(b_green_led), .red_led(b_red_led), .lock_led(b_lock_led),
    .digit_display(b_digit_display), .tries_left(b_tries_left)
  );

  // Behavioural synchronous ROMs with the configured read latency.
  logic [DW-1:0]   rom_a [32];
  logic [DW-1:0]   pipe_a [RL];
  logic [B_DW-1:0] rom_b [32];
  logic [B_DW-1:0] pipe_b [B_RL];

  always @(posedge clk) begin
    pipe_a[0] <= rom_a[rom_addr];
    for (int k = 1; k < RL; k++) pipe_a[k] <= pipe_a[k-1];
    pipe_b[0] <= rom_b[b_rom_addr];
    for (int k = 1; k < B_RL; k++) pipe_b[k] <= pipe_b[k-1];
  end
  assign rom_data   = pipe_a[RL-1];
  assign b_rom_data = pipe_b[B_RL-1];

  int checks = 0;
  int errors = 0;
  int tries_a = MT;
  int tries_b = MT;
  logic [DW-1:0]   entry_a [ND];
  logic [B_DW-1:0] entry_b [B_ND];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_entry(input logic [15:0] v);
    for (int i = 0; i < ND; i++) entry_a[i] = v[15-4*i -: 4];
  endtask

  // Reference rule: the entry matches when digit i equals ROM[(base+i) mod 32].
  function automatic bit pwd_ok_a(input int base);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < ND; i++) if (entry_a[i] !== rom_a[(base + i) % 32]) ok = 1'b0;
    return ok;
  endfunction

  task automatic type_entry_a(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      load_digit = 1'b1;
      digit_in   = entry_a[i];
      tick();
      load_digit = 1'b0;
    end
  endtask

  task automatic attempt_a(input int base, input string tag);
    int lat;
    bit ok;
    base_addr = AW'(base);
    repeat (2) tick();
    ok = pwd_ok_a(base);
    type_entry_a(ND);
    lat = 0;
    while (!(green_led === 1'b1 || lock_led === 1'b1 || tries_left !== 2'(tries_a)) && lat < 200) begin
      tick();
      lat++;
    end
    if (ok) tries_a = MT;
    else tries_a = tries_a - 1;
    check({tag, "_latency"}, 64'(lat), 64'(ND * (RL + 2) + 1));
    check({tag, "_green"}, 64'(green_led), 64'(ok));
    check({tag, "_red"}, 64'(red_led), 64'(!ok));
    check({tag, "_tries"}, 64'(tries_left), 64'(tries_a));
    check({tag, "_lock"}, 64'(lock_led), 64'(tries_a == 0));
    check({tag, "_display"}, 64'(digit_display), 64'(entry_a[ND-1]));
  endtask

  task automatic logout_a(input string tag);
    logout = 1'b1;
    tick();
    logout = 1'b0;
    check({tag, "_green"}, 64'(green_led), 64'(0));
    check({tag, "_red"}, 64'(red_led), 64'(1));
    check({tag, "_display"}, 64'(digit_display), 64'(0));
  endtask

  // Count lockout cycles while hammering load_digit, which must be ignored.
  task automatic wait_lockout_a(input string tag);
    int cnt;
    cnt = 0;
    while (lock_led === 1'b1 && cnt < LC + 50) begin
      cnt++;
      load_digit = 1'($urandom_range(0, 1));
      digit_in   = DW'($urandom);
      tick();
    end
    load_digit = 1'b0;
    tries_a = MT;
    check({tag, "_cycles"}, 64'(cnt), 64'(LC));
    check({tag, "_lock_after"}, 64'(lock_led), 64'(0));
    check({tag, "_tries_after"}, 64'(tries_left), 64'(MT));
    check({tag, "_red_after"}, 64'(red_led), 64'(1));
    check({tag, "_display_after"}, 64'(digit_display), 64'(entry_a[ND-1]));
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_red"}, 64'(red_led), 64'(1));
    check({tag, "_green"}, 64'(green_led), 64'(0));
    check({tag, "_lock"}, 64'(lock_led), 64'(0));
    check({tag, "_tries"}, 64'(tries_left), 64'(MT));
    check({tag, "_display"}, 64'(digit_display), 64'(0));
    check({tag, "_rom_addr"}, 64'(rom_addr), 64'(0));
  endtask

  task automatic attempt_b(input int base, input bit correct, input string tag);
    int lat;
    bit ok;
    b_base_addr = AW'(base);
    repeat (2) tick();
    for (int i = 0; i < B_ND; i++)
      entry_b[i] = correct ? rom_b[(base + i) % 32] : B_DW'($urandom);
    if (!correct) entry_b[0] = rom_b[base % 32] ^ 8'h5A;
    ok = 1'b1;
    for (int i = 0; i < B_ND; i++) if (entry_b[i] !== rom_b[(base + i) % 32]) ok = 1'b0;
    for (int i = 0; i < B_ND; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      b_load_digit = 1'b1;
      b_digit_in   = entry_b[i];
      tick();
      b_load_digit = 1'b0;
    end
    lat = 0;
    while (!(b_green_led === 1'b1 || b_lock_led === 1'b1 || b_tries_left !== 2'(tries_b)) && lat < 200) begin
      tick();
      lat++;
    end
    if (ok) tries_b = MT;
    else tries_b = tries_b - 1;
    check({tag, "_latency"}, 64'(lat), 64'(B_ND * (B_RL + 2) + 1));
    check({tag, "_green"}, 64'(b_green_led), 64'(ok));
    check({tag, "_tries"}, 64'(b_tries_left), 64'(tries_b));
    check({tag, "_display"}, 64'(b_digit_display), 64'(entry_b[B_ND-1]));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      rom_a[i] = DW'($urandom);
      rom_b[i] = B_DW'($urandom);
    end
    rom_a[4] = 4'd3;  rom_a[5] = 4'd7;  rom_a[6] = 4'd1; rom_a[7] = 4'd9;
    rom_a[30] = 4'd2; rom_a[31] = 4'd2; rom_a[0] = 4'd5; rom_a[1] = 4'd5;

    reset = 1'b0; user_id_ok = 1'b0; load_digit = 1'b0; logout = 1'b0;
    digit_in = '0; base_addr = '0;
    b_user_id_ok = 1'b0; b_load_digit = 1'b0; b_logout = 1'b0;
    b_digit_in = '0; b_base_addr = '0;
    repeat (3) tick();
    check_reset_a("reset");
    check("b_reset_red", 64'(b_red_led), 64'(1));
    check("b_reset_tries", 64'(b_tries_left), 64'(MT));
    reset = 1'b1;
    user_id_ok = 1'b1;

    // Correct password, then logout.
    set_entry(16'h3719); attempt_a(4, "correct");
    logout_a("logout1");

    // One wrong entry then a correct retry restores the try count.
    set_entry(16'h3718); attempt_a(4, "wrong1");
    set_entry(16'h3719); attempt_a(4, "retry_ok");
    logout_a("logout2");

    // Three failures lock the controller out.
    set_entry(16'h3718); attempt_a(4, "lk_w1");
    set_entry(16'h0000); attempt_a(4, "lk_w2");
    set_entry(16'h9173); attempt_a(4, "lk_w3");
    wait_lockout_a("lockout");

    // Address wrap from 31 to 0.
    set_entry(16'h2255); attempt_a(30, "wrap");
    logout_a("logout3");

    // Dropping user ID mid-entry discards the partial entry but keeps tries.
    set_entry(16'h3718); attempt_a(4, "pre_drop");
    set_entry(16'h3719);
    base_addr = AW'(4);
    repeat (2) tick();
    type_entry_a(2);
    user_id_ok = 1'b0;
    repeat (30) tick();
    check("drop_green", 64'(green_led), 64'(0));
    check("drop_red", 64'(red_led), 64'(1));
    check("drop_tries", 64'(tries_left), 64'(tries_a));
    user_id_ok = 1'b1;
    attempt_a(4, "reentry");
    logout_a("logout4");

    // Reset while waiting on the ROM.
    set_entry(16'h1111); attempt_a(4, "pre_rst_wait");
    set_entry(16'h3719);
    base_addr = AW'(4);
    repeat (2) tick();
    type_entry_a(ND);
    repeat (2) tick();
    check("wait_rom_addr", 64'(rom_addr), 64'(4));
    reset = 1'b0;
    tick();
    check_reset_a("rst_wait");
    reset = 1'b1;
    tries_a = MT; tries_b = MT;

    // Reset while locked out.
    set_entry(16'h3718); attempt_a(4, "rl_w1");
    set_entry(16'h3718); attempt_a(4, "rl_w2");
    set_entry(16'h3718); attempt_a(4, "rl_w3");
    repeat (5) tick();
    check("rst_lock_pre", 64'(lock_led), 64'(1));
    reset = 1'b0;
    tick();
    check_reset_a("rst_lock");
    reset = 1'b1;
    tries_a = MT; tries_b = MT;

    // Randomised attempts against the reference rule.
    for (int t = 0; t < 12; t++) begin
      int base;
      case ($urandom_range(0, 2))
        0: base = 4;
        1: base = 30;
        default: base = int'($urandom_range(0, 31));
      endcase
      for (int i = 0; i < ND; i++)
        entry_a[i] = ($urandom_range(0, 1) == 1) ? rom_a[(base + i) % 32] : DW'($urandom);
      attempt_a(base, $sformatf("rand%0d", t));
      if (green_led === 1'b1) logout_a($sformatf("rand%0d_logout", t));
      else if (lock_led === 1'b1) wait_lockout_a($sformatf("rand%0d_lockout", t));
    end
    user_id_ok = 1'b0;

    // Wide-digit, single-cycle-latency instance.
    b_user_id_ok = 1'b1;
    attempt_b(9, 1'b1, "b_ok");
    b_logout = 1'b1; tick(); b_logout = 1'b0;
    check("b_logout_red", 64'(b_red_led), 64'(1));
    attempt_b(12, 1'b0, "b_bad");
    attempt_b(30, 1'b1, "b_wrap");
    b_user_id_ok = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
